// File: rtl/load_store_unit.sv
// Byte-serial load/store sequencer for a byte-wide, synchronous-read data memory.
// Requests are split into little-endian byte accesses; loads are reassembled and extended.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  input  logic [7:0]            mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, LAST, RESP} state_t;

  state_t                state, state_nxt;
  logic [1:0]            k;
  logic                  we_p0;
  logic [1:0]            size_p0;
  logic                  uns_p0;
  logic [ADDR_WIDTH-1:0] base_p0;
  logic [31:0]           wdata_p0;
  logic [31:0]           rbuf_p0;
  logic [31:0]           assembled;
  logic [1:0]            last_k;
  logic [1:0]            k_prev;

  function automatic logic [1:0] final_index(input logic [1:0] size);
    case (size)
      2'b00:   final_index = 2'd0;
      2'b01:   final_index = 2'd1;
      default: final_index = 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                              input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[7:0];
    h = word[15:0];
    case (size)
      2'b00:   load_extend = uns ? {24'd0, word[7:0]}  : 32'(b);
      2'b01:   load_extend = uns ? {16'd0, word[15:0]} : 32'(h);
      default: load_extend = word;
    endcase
  endfunction

  assign last_k = final_index(size_p0);
  assign k_prev = k - 2'd1;

  // The final byte arrives during LAST and is merged straight into the result.
  always_comb begin
    assembled = rbuf_p0;
    assembled[{last_k, 3'b000} +: 8] = mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = 8'd0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = (req_size == 2'b11) ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_addr = base_p0 + ADDR_WIDTH'(k);
        if (we_p0) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_p0[{k, 3'b000} +: 8];
        end
        if (k == last_k) state_nxt = we_p0 ? RESP : LAST;
      end
      LAST: state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, read-byte collection and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k          <= 2'd0;
      we_p0      <= 1'b0;
      size_p0    <= 2'd0;
      uns_p0     <= 1'b0;
      base_p0    <= '0;
      wdata_p0   <= 32'd0;
      rbuf_p0    <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_p0    <= req_we;
            size_p0  <= req_size;
            uns_p0   <= req_unsigned;
            base_p0  <= req_addr;
            wdata_p0 <= req_wdata;
            k        <= 2'd0;
            rbuf_p0  <= 32'd0;
            if (req_size == 2'b11) begin
              resp_rdata <= 32'd0;
              resp_err   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // Memory read data lags its address by one cycle.
          if (!we_p0 && k != 2'd0) rbuf_p0[{k_prev, 3'b000} +: 8] <= mem_rdata;
          k <= k + 2'd1;
          if (k == last_k && we_p0) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
          end
        end
        LAST: begin
          resp_rdata <= load_extend(size_p0, uns_p0, assembled);
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
